// File: rtl/ebr_pkg.sv
// rtl/ebr_pkg.sv - shared enums and parameter-string helpers for the dual-port EBR model
package ebr_pkg;

    typedef enum logic {NOREG, OUTREG} regmode_e;
    typedef enum logic [1:0] {NORMAL, WRITETHROUGH, READBEFOREWRITE} writemode_e;

    localparam int MAX_DATA_W = 36;

    function automatic bit regmode_ok(input string s);
        return (s == "NOREG") || (s == "OUTREG");
    endfunction

    function automatic regmode_e to_regmode(input string s);
        return (s == "OUTREG") ? OUTREG : NOREG;
    endfunction

    function automatic bit writemode_ok(input string s);
        return (s == "NORMAL") || (s == "WRITETHROUGH") || (s == "READBEFOREWRITE");
    endfunction

    function automatic writemode_e to_writemode(input string s);
        if (s == "WRITETHROUGH") return WRITETHROUGH;
        if (s == "READBEFOREWRITE") return READBEFOREWRITE;
        return NORMAL;
    endfunction

endpackage

// File: rtl/ebr_read_port.sv
// rtl/ebr_read_port.sv - per-port read latch, write-mode mux and optional output register
module ebr_read_port
    import ebr_pkg::*;
#(
    parameter int         DATA_W    = 9,
    parameter regmode_e   REGMODE   = NOREG,
    parameter writemode_e WRITEMODE = NORMAL
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              sel,
    input  logic              we,
    input  logic              oce,
    input  logic [DATA_W-1:0] di,
    input  logic [DATA_W-1:0] old_word,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] latch_q;

    // old_word is sampled before the array update, giving old-data semantics
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            latch_q <= '0;
        end else if (sel) begin
            if (!we) begin
                latch_q <= old_word;
            end else begin
                case (WRITEMODE)
                    WRITETHROUGH:    latch_q <= di;
                    READBEFOREWRITE: latch_q <= old_word;
                    default:         latch_q <= latch_q;
                endcase
            end
        end
    end

    generate
        if (REGMODE == OUTREG) begin : g_outreg
            logic [DATA_W-1:0] oreg_q;
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    oreg_q <= '0;
                end else if (oce) begin
                    oreg_q <= latch_q;
                end
            end
            assign rd_data = oreg_q;
        end else begin : g_noreg
            logic unused_oce;
            assign unused_oce = oce;
            assign rd_data    = latch_q;
        end
    endgenerate

endmodule

// File: rtl/ebr_dp_sync.sv
// rtl/ebr_dp_sync.sv - single-clock true dual-port EBR with port-A write priority
module ebr_dp_sync
    import ebr_pkg::*;
#(
    parameter int          DATA_W      = 9,
    parameter int          ADDR_W      = 10,
    parameter string       REGMODE_A   = "NOREG",
    parameter string       REGMODE_B   = "NOREG",
    parameter string       WRITEMODE_A = "NORMAL",
    parameter string       WRITEMODE_B = "NORMAL",
    parameter logic [2:0]  CSDECODE_A  = 3'b000,
    parameter logic [2:0]  CSDECODE_B  = 3'b000,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic              CLK,
    input  logic              RSTN,
    input  logic              CEA,
    input  logic              CEB,
    input  logic              OCEA,
    input  logic              OCEB,
    input  logic              WEA,
    input  logic              WEB,
    input  logic [2:0]        CSA,
    input  logic [2:0]        CSB,
    input  logic [ADDR_W-1:0] ADA,
    input  logic [ADDR_W-1:0] ADB,
    input  logic [DATA_W-1:0] DIA,
    input  logic [DATA_W-1:0] DIB,
    output logic [DATA_W-1:0] DOA,
    output logic [DATA_W-1:0] DOB
);

    localparam int DEPTH = 1 << ADDR_W;

    generate
        if (DATA_W < 1 || DATA_W > MAX_DATA_W ||
            !regmode_ok(REGMODE_A) || !regmode_ok(REGMODE_B) ||
            !writemode_ok(WRITEMODE_A) || !writemode_ok(WRITEMODE_B)) begin : g_bad_param
            $fatal(1, "ebr_dp_sync: illegal parameter value");
        end
    endgenerate

    localparam regmode_e   RM_A = to_regmode(REGMODE_A);
    localparam regmode_e   RM_B = to_regmode(REGMODE_B);
    localparam writemode_e WM_A = to_writemode(WRITEMODE_A);
    localparam writemode_e WM_B = to_writemode(WRITEMODE_B);

    logic [DATA_W-1:0] mem [DEPTH] = '{default: INIT_VAL};

    logic sel_a, sel_b;
    logic wr_a, wr_b;

    assign sel_a = CEA && (CSA == CSDECODE_A);
    assign sel_b = CEB && (CSB == CSDECODE_B);
    assign wr_a  = sel_a && WEA;
    assign wr_b  = sel_b && WEB;

    // Array is never cleared; reset only blocks writes. A is written last so it wins a tie.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (RSTN) begin
            if (wr_b) mem[ADB] <= DIB;
            if (wr_a) mem[ADA] <= DIA;
        end
    end

    ebr_read_port #(
        .DATA_W   (DATA_W),
        .REGMODE  (RM_A),
        .WRITEMODE(WM_A)
    ) u_port_a (
        .clk     (CLK),
        .rstn    (RSTN),
        .sel     (sel_a),
        .we      (WEA),
        .oce     (OCEA),
        .di      (DIA),
        .old_word(mem[ADA]),
        .rd_data (DOA)
    );

    ebr_read_port #(
        .DATA_W   (DATA_W),
        .REGMODE  (RM_B),
        .WRITEMODE(WM_B)
    ) u_port_b (
        .clk     (CLK),
        .rstn    (RSTN),
        .sel     (sel_b),
        .we      (WEB),
        .oce     (OCEB),
        .di      (DIB),
        .old_word(mem[ADB]),
        .rd_data (DOB)
    );

endmodule
